change_dispenser: RTL and testbench

//   Sits downstream of vending_machine. Takes the change amount owed (cents) and pays it out
//   as one-hot coin-eject pulses, largest denomination first (greedy).

---
 rtl/vm_pkg.sv | 27 ++
 rtl/coin_inventory.sv | 49 ++++
 rtl/change_dispenser.sv | 155 +++++++++++++++
 tb/tb_change_dispenser.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared denominations and payout FSM states
// Denomination indices, the cents value of each tube and the
// change_dispenser state enum.
package vm_pkg;

    localparam int NUM_DEN = 6;

    localparam int DEN_5C  = 0;
    localparam int DEN_10C = 1;
    localparam int DEN_25C = 2;
    localparam int DEN_50C = 3;
    localparam int DEN_1D  = 4;
    localparam int DEN_5D  = 5;

    // Cents per coin, indexed by tube number; ascending so the greedy
    // search can simply keep the last qualifying index.
    localparam int DENOM_CENTS [NUM_DEN] = '{5, 10, 25, 50, 100, 500};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_PULSE,
        ST_GAP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/coin_inventory.sv
// rtl/coin_inventory.sv - six tube coin counters with load and decrement
// Ports:
//   clk, rst          clock, synchronous active-high reset (tubes -> INIT_COUNT)
//   load_en/load_den  overwrite tube load_den with load_cnt (indices 6,7 ignored)
//   dec_en/dec_den    remove one coin from tube dec_den (never below zero)
//   nonzero           per-tube "has at least one coin" flag
module coin_inventory
    import vm_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int INIT_COUNT = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic [2:0]         load_den,
    input  logic [CNT_W-1:0]   load_cnt,
    input  logic               dec_en,
    input  logic [2:0]         dec_den,
    output logic [NUM_DEN-1:0] nonzero
);

    logic [NUM_DEN-1:0][CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DEN; i++) begin
                count[i] <= CNT_W'(INIT_COUNT);
            end
        end else begin
            for (int i = 0; i < NUM_DEN; i++) begin
                if (load_en && load_den == 3'(i)) begin
                    count[i] <= load_cnt;
                end
                if (dec_en && dec_den == 3'(i) && count[i] != '0) begin
                    count[i] <= count[i] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        nonzero = '0;
        for (int i = 0; i < NUM_DEN; i++) begin
            nonzero[i] = (count[i] != '0);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy coin payout with tube inventory
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   start, change_amt            request payout of change_amt cents (IDLE only)
//   load_en, load_den, load_cnt  tube refill (IDLE only)
//   busy, done                   payout in progress / 1-cycle end pulse
//   short_flag, remaining        unpaid result, valid from done
//   coin_out                     one-hot eject pulse, bit i = tube i
//   change_five_led              lit once a $5 coin has been ejected
module change_dispenser
    import vm_pkg::*;
#(
    parameter int AMT_W      = 13,
    parameter int CNT_W      = 8,
    parameter int INIT_COUNT = 20,
    parameter int PULSE_CYC  = 4,
    parameter int GAP_CYC    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AMT_W-1:0] change_amt,
    input  logic             load_en,
    input  logic [2:0]       load_den,
    input  logic [CNT_W-1:0] load_cnt,
    output logic             busy,
    output logic             done,
    output logic             short_flag,
    output logic [AMT_W-1:0] remaining,
    output logic [5:0]       coin_out,
    output logic             change_five_led
);

    localparam int TMR_W = 8;

    state_t             state;
    state_t             state_next;
    logic [AMT_W-1:0]   amt;
    logic [2:0]         sel_den;
    logic [TMR_W-1:0]   timer;
    logic [NUM_DEN-1:0] nonzero;
    logic               pick_found;
    logic [2:0]         pick_den;
    logic [AMT_W-1:0]   pick_cents;

    coin_inventory #(
        .CNT_W      (CNT_W),
        .INIT_COUNT (INIT_COUNT)
    ) u_inv (
        .clk      (clk),
        .rst      (rst),
        .load_en  (load_en && state == ST_IDLE),
        .load_den (load_den),
        .load_cnt (load_cnt),
        .dec_en   (state == ST_SELECT && pick_found),
        .dec_den  (pick_den),
        .nonzero  (nonzero)
    );

    // Greedy choice: largest stocked coin that still fits in amt.
    always_comb begin
        pick_found = 1'b0;
        pick_den   = '0;
        pick_cents = '0;
        for (int i = 0; i < NUM_DEN; i++) begin
            if (nonzero[i] && AMT_W'(DENOM_CENTS[i]) <= amt) begin
                pick_found = 1'b1;
                pick_den   = 3'(i);
                pick_cents = AMT_W'(DENOM_CENTS[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        coin_out   = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SELECT;
                end
            end
            ST_SELECT: begin
                busy       = 1'b1;
                state_next = pick_found ? ST_PULSE : ST_DONE;
            end
            ST_PULSE: begin
                busy     = 1'b1;
                coin_out = 6'(1) << sel_den;
                if (timer == TMR_W'(PULSE_CYC - 1)) begin
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                busy = 1'b1;
                if (timer == TMR_W'(GAP_CYC - 1)) begin
                    state_next = ST_SELECT;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            amt             <= '0;
            sel_den         <= '0;
            timer           <= '0;
            short_flag      <= 1'b0;
            remaining       <= '0;
            change_five_led <= 1'b0;
        end else begin
            // Timer restarts on every state change so PULSE and GAP
            // each count from zero.
            timer <= (state_next != state) ? '0 : timer + TMR_W'(1);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        amt             <= change_amt;
                        short_flag      <= 1'b0;
                        change_five_led <= 1'b0;
                    end
                end
                ST_SELECT: begin
                    if (pick_found) begin
                        amt     <= amt - pick_cents;
                        sel_den <= pick_den;
                        if (pick_den == 3'(DEN_5D)) begin
                            change_five_led <= 1'b1;
                        end
                    end else begin
                        short_flag <= (amt != '0);
                        remaining  <= amt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - self-checking bench for change_dispenser
module tb_change_dispenser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [12:0] change_amt = '0;
    logic        load_en = 1'b0;
    logic [2:0]  load_den = '0;
    logic [7:0]  load_cnt = '0;
    logic        busy;
    logic        done;
    logic        short_flag;
    logic [12:0] remaining;
    logic [5:0]  coin_out;
    logic        change_five_led;

    change_dispenser dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .change_amt      (change_amt),
        .load_en         (load_en),
        .load_den        (load_den),
        .load_cnt        (load_cnt),
        .busy            (busy),
        .done            (done),
        .short_flag      (short_flag),
        .remaining       (remaining),
        .coin_out        (coin_out),
        .change_five_led (change_five_led)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] coin;
        bit         busy;
        bit         done;
        bit         led;
        bit         led_chk;
        bit         res_chk;
        bit         short_f;
        int         rem;
    } exp_t;

    int   den_tab [6] = '{5, 10, 25, 50, 100, 500};
    int   inv [6];
    exp_t exp_q [$];

    int         checks = 0;
    int         failures = 0;
    int         pop_n = 0;
    int         act_done_idx = -1;
    int         act_short = -1;
    int         act_rem = -1;
    logic [5:0] prev_coin = '0;
    int         act_coins [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Per-cycle compare against the expected timeline.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("coin_out", int'(coin_out), int'(e.coin));
            chk("busy", int'(busy), int'(e.busy));
            chk("done", int'(done), int'(e.done));
            if (e.led_chk) chk("led", int'(change_five_led), int'(e.led));
            if (e.res_chk) begin
                chk("short_flag", int'(short_flag), int'(e.short_f));
                chk("remaining", int'(remaining), e.rem);
            end
            if (done) begin
                act_done_idx = pop_n;
                act_short    = int'(short_flag);
                act_rem      = int'(remaining);
            end
            if (coin_out != '0 && coin_out != prev_coin) act_coins.push_back(int'(coin_out));
            prev_coin = coin_out;
            pop_n++;
        end
    end

    function automatic exp_t mk(input logic [5:0] coin, input bit b, input bit d,
                                input bit led, input bit lchk, input bit rchk,
                                input bit sh, input int rem);
        exp_t e;
        e.coin = coin; e.busy = b; e.done = d; e.led = led;
        e.led_chk = lchk; e.res_chk = rchk; e.short_f = sh; e.rem = rem;
        return e;
    endfunction

    // Greedy payout model: one select cycle per coin decision, then
    // 4 pulse cycles and 2 gap cycles per coin, then the done cycle.
    task automatic build_model(input int amt);
        int a = amt;
        bit led_m = 1'b0;
        int best;
        exp_q.push_back(mk(6'd0, 0, 0, 0, 0, 0, 0, 0));
        forever begin
            exp_q.push_back(mk(6'd0, 1, 0, led_m, 1, 0, 0, 0));
            best = -1;
            for (int i = 0; i < 6; i++)
                if (inv[i] > 0 && den_tab[i] <= a) best = i;
            if (best < 0) break;
            a -= den_tab[best];
            inv[best]--;
            if (best == 5) led_m = 1'b1;
            repeat (4) exp_q.push_back(mk(6'(1 << best), 1, 0, led_m, 1, 0, 0, 0));
            repeat (2) exp_q.push_back(mk(6'd0, 1, 0, led_m, 1, 0, 0, 0));
        end
        exp_q.push_back(mk(6'd0, 0, 1, led_m, 1, 1, a != 0, a));
        exp_q.push_back(mk(6'd0, 0, 0, led_m, 1, 1, a != 0, a));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) inv[i] = 20;
    endtask

    task automatic do_load(input int den, input int cnt);
        load_en = 1'b1; load_den = 3'(den); load_cnt = 8'(cnt);
        @(posedge clk);
        #1 load_en = 1'b0;
        if (den < 6) inv[den] = cnt;
    endtask

    task automatic run_payout(input int amt, input bit interfere);
        int k = 0;
        pop_n = 0; act_done_idx = -1; act_short = -1; act_rem = -1;
        prev_coin = '0; act_coins.delete();
        build_model(amt);
        start = 1'b1; change_amt = 13'(amt);
        @(posedge clk);
        #1 start = 1'b0; load_en = 1'b0;
        while (exp_q.size() > 0 && k < 200) begin
            if (interfere && k == 10) begin
                start = 1'b1; change_amt = 13'd5;
                load_en = 1'b1; load_den = 3'd5; load_cnt = 8'd0;
            end else if (interfere && k == 11) begin
                start = 1'b0; load_en = 1'b0;
            end
            @(posedge clk);
            #1 k++;
        end
        chk("payout_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic chk_counts(input string name);
        for (int i = 0; i < 6; i++) chk(name, int'(dut.u_inv.count[i]), inv[i]);
    endtask

    initial begin
        int coins1 [6] = '{32, 16, 8, 4, 2, 1};

        do_reset();
        chk("rst_coin_out", int'(coin_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_short", int'(short_flag), 0);
        chk("rst_remaining", int'(remaining), 0);
        chk("rst_led", int'(change_five_led), 0);
        for (int i = 0; i < 6; i++) chk("rst_count", int'(dut.u_inv.count[i]), 20);

        // 690 cents with full tubes, plus ignored start/load mid-payout
        run_payout(690, 1'b1);
        chk("t1_done_cycle", act_done_idx, 44);
        chk("t1_short", act_short, 0);
        chk("t1_rem", act_rem, 0);
        chk("t1_led", int'(change_five_led), 1);
        chk("t1_num_coins", act_coins.size(), 6);
        for (int i = 0; i < 6 && i < act_coins.size(); i++) chk("t1_coin_order", act_coins[i], coins1[i]);
        for (int i = 0; i < 6; i++) chk("t1_count", int'(dut.u_inv.count[i]), 19);

        // Empty the 25c tube in the same cycle as start: pay 30 as 3 x 10c
        do_reset();
        load_en = 1'b1; load_den = 3'd2; load_cnt = 8'd0;
        inv[2] = 0;
        run_payout(30, 1'b0);
        chk("t2_short", act_short, 0);
        chk("t2_num_coins", act_coins.size(), 3);
        chk("t2_count1", int'(dut.u_inv.count[1]), 17);
        chk("t2_count2", int'(dut.u_inv.count[2]), 0);
        chk("t2_led", int'(change_five_led), 0);
        chk_counts("t2_model_count");

        // 7 cents: one nickel, 2c shortfall
        do_reset();
        run_payout(7, 1'b0);
        chk("t3_short", act_short, 1);
        chk("t3_rem", act_rem, 2);
        chk("t3_num_coins", act_coins.size(), 1);

        // No 5c or 10c coins: 5 cents cannot be paid
        do_load(0, 0);
        do_load(1, 0);
        run_payout(5, 1'b0);
        chk("t4_done_cycle", act_done_idx, 2);
        chk("t4_short", act_short, 1);
        chk("t4_rem", act_rem, 5);
        chk("t4_num_coins", act_coins.size(), 0);

        // Zero change
        run_payout(0, 1'b0);
        chk("t5_done_cycle", act_done_idx, 2);
        chk("t5_short", act_short, 0);
        chk("t5_rem", act_rem, 0);
        chk_counts("t5_model_count");

        // Reset during the first $5 pulse
        do_reset();
        start = 1'b1; change_amt = 13'd690;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 chk("t6_pulse_before_rst", int'(coin_out), 32);
        chk("t6_busy_before_rst", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1 chk("t6_coin_after_rst", int'(coin_out), 0);
        chk("t6_busy_after_rst", int'(busy), 0);
        chk("t6_led_after_rst", int'(change_five_led), 0);
        for (int i = 0; i < 6; i++) chk("t6_count_after_rst", int'(dut.u_inv.count[i]), 20);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
